// File: rtl/flit_packetizer.sv
// rtl/flit_packetizer.sv - splits one wide message into a multi-flit packet
// Flit layout {valid, is_tail, dest, vc, data}; chunk 0 (message LSBs) goes first.
module flit_packetizer #(
  parameter int MSG_WIDTH       = 128,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 4,
  parameter int VC_BITS         = 2,
  parameter int VC_ID           = 1,
  localparam int FLIT_W         = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [MSG_WIDTH-1:0] msg_data,
  input  logic [DEST_BITS-1:0] msg_dest,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  output logic [FLIT_W-1:0]    put_flit,
  output logic                 put_flit_valid,
  input  logic                 put_flit_ready,
  output logic                 busy
);

  localparam int NUM_FLITS_RAW = (MSG_WIDTH + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
  localparam int NUM_FLITS     = (NUM_FLITS_RAW < 1) ? 1 : NUM_FLITS_RAW;
  localparam int CNT_W         = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int PAD_W         = NUM_FLITS * FLIT_DATA_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic   [PAD_W-1:0]         r_msg;
  logic   [DEST_BITS-1:0]     r_dest;
  logic   [CNT_W-1:0]         r_idx;
  logic   [PAD_W-1:0]         w_msg_pad;
  logic   [FLIT_DATA_WIDTH-1:0] w_data;
  logic                       w_tail;
  logic                       w_flit_fire;
  logic                       w_msg_fire;
  int                         w_base;

  // Zero-extending on capture keeps the final chunk's padding clean for every message.
  always_comb begin
    w_msg_pad = '0;
    w_msg_pad[MSG_WIDTH-1:0] = msg_data;
  end

  always_comb begin
    w_base = int'(r_idx) * FLIT_DATA_WIDTH;
    w_data = r_msg[w_base +: FLIT_DATA_WIDTH];
  end

  assign w_tail         = (r_idx == CNT_W'(NUM_FLITS - 1));
  assign busy           = !RST && (r_state == SEND);
  assign put_flit_valid = busy;
  assign msg_ready      = !RST && ((r_state == IDLE) ||
                                   ((r_state == SEND) && w_tail && put_flit_ready));
  assign w_flit_fire    = put_flit_valid && put_flit_ready;
  assign w_msg_fire     = msg_valid && msg_ready;
  assign put_flit       = put_flit_valid ?
                          {1'b1, w_tail, r_dest, VC_BITS'(VC_ID), w_data} : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (msg_valid) w_next_state = SEND;
      SEND:    if (w_flit_fire && w_tail && !msg_valid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_msg   <= '0;
      r_dest  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_msg_fire) begin
        r_msg  <= w_msg_pad;
        r_dest <= msg_dest;
        r_idx  <= '0;
      end else if (w_flit_fire && !w_tail) begin
        r_idx <= r_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_flit_packetizer.sv
// tb/tb_flit_packetizer.sv - scoreboard bench for flit_packetizer
// Instance a: 100-bit messages in 4 flits; instance b: 32-bit messages in 1 flit.
module tb_flit_packetizer;

  logic        CLK = 1'b0;
  logic        RST;

  logic [99:0] msg_data_a;
  logic [3:0]  msg_dest_a;
  logic        msg_valid_a, msg_ready_a;
  logic [39:0] put_flit_a;
  logic        put_flit_valid_a, put_flit_ready_a, busy_a;

  logic [31:0] msg_data_b;
  logic [3:0]  msg_dest_b;
  logic        msg_valid_b, msg_ready_b;
  logic [39:0] put_flit_b;
  logic        put_flit_valid_b, put_flit_ready_b, busy_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [39:0] q_a[$];
  logic [39:0] q_b[$];
  int          fires_a = 0, fires_b = 0;
  int          neg_cnt_a = 0, last_fire_a = 0, valid_cnt_a = 0;
  logic        stall_pending = 1'b0;
  logic [39:0] held_flit;

  flit_packetizer #(.MSG_WIDTH(100), .FLIT_DATA_WIDTH(32), .DEST_BITS(4),
                    .VC_BITS(2), .VC_ID(1)) dut_a (
    .CLK(CLK), .RST(RST),
    .msg_data(msg_data_a), .msg_dest(msg_dest_a),
    .msg_valid(msg_valid_a), .msg_ready(msg_ready_a),
    .put_flit(put_flit_a), .put_flit_valid(put_flit_valid_a),
    .put_flit_ready(put_flit_ready_a), .busy(busy_a)
  );

  flit_packetizer #(.MSG_WIDTH(32), .FLIT_DATA_WIDTH(32), .DEST_BITS(4),
                    .VC_BITS(2), .VC_ID(1)) dut_b (
    .CLK(CLK), .RST(RST),
    .msg_data(msg_data_b), .msg_dest(msg_dest_b),
    .msg_valid(msg_valid_b), .msg_ready(msg_ready_b),
    .put_flit(put_flit_b), .put_flit_valid(put_flit_valid_b),
    .put_flit_ready(put_flit_ready_b), .busy(busy_b)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] exp_flit_a(input logic [99:0] d, input logic [3:0] dest,
                                              input int i);
    logic [127:0] pad;
    logic [31:0]  chunk;
    pad   = {28'd0, d};
    chunk = pad[i*32 +: 32];
    return {1'b1, (i == 3), dest, 2'd1, chunk};
  endfunction

  // Monitor for instance a: scoreboard pops, stall stability, msg_ready shape.
  always @(negedge CLK) begin
    neg_cnt_a++;
    if (put_flit_valid_a) valid_cnt_a++;
    if (stall_pending) begin
      check("stall_hold_valid", put_flit_valid_a, 1);
      check("stall_hold_flit", put_flit_a, held_flit);
    end
    if (busy_a && !(put_flit_a[38] && put_flit_ready_a))
      check("msg_ready_low_midpacket", msg_ready_a, 0);
    if (put_flit_valid_a && put_flit_ready_a) begin
      if (put_flit_a[38]) check("msg_ready_on_tail_fire", msg_ready_a, 1);
      if (q_a.size() == 0) check("unexpected_flit_a", put_flit_a, 0);
      else check("flit_a", put_flit_a, q_a.pop_front());
      fires_a++;
      last_fire_a = neg_cnt_a;
    end
    stall_pending = put_flit_valid_a && !put_flit_ready_a;
    held_flit     = put_flit_a;
  end

  always @(negedge CLK) begin
    if (put_flit_valid_b && put_flit_ready_b) begin
      if (q_b.size() == 0) check("unexpected_flit_b", put_flit_b, 0);
      else check("flit_b", put_flit_b, q_b.pop_front());
      fires_b++;
    end
  end

  // Leaves msg_valid_a high; the caller drops it unless chaining another message.
  task automatic offer_a(input logic [99:0] d, input logic [3:0] dest);
    bit ok;
    ok = 0;
    msg_data_a  = d;
    msg_dest_a  = dest;
    msg_valid_a = 1'b1;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge CLK);
      if (msg_ready_a) ok = 1;
    end
    check("msg_accept_a", ok, 1);
    if (ok) for (int i = 0; i < 4; i++) q_a.push_back(exp_flit_a(d, dest, i));
    @(posedge CLK); #1;
    if (ok) check("first_flit_latency", put_flit_valid_a, 1);
  endtask

  task automatic drain_a();
    for (int c = 0; c < 100; c++) begin
      if (q_a.size() == 0) break;
      @(posedge CLK); #1;
    end
    check("drain_a", q_a.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, n0, v0;
    logic [31:0] vals_b[5];
    RST = 1'b1;
    msg_data_a = '0; msg_dest_a = '0; msg_valid_a = 1'b0; put_flit_ready_a = 1'b1;
    msg_data_b = '0; msg_dest_b = '0; msg_valid_b = 1'b0; put_flit_ready_b = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_msg_ready", msg_ready_a, 0);
    check("rst_valid", put_flit_valid_a, 0);
    check("rst_flit", put_flit_a, 0);
    check("rst_busy", busy_a, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("idle_msg_ready_a", msg_ready_a, 1);
    check("idle_msg_ready_b", msg_ready_b, 1);
    check("idle_busy", busy_a, 0);
    @(posedge CLK); #1;

    // Single packet with downstream always ready.
    offer_a(100'hF_DEADBEEF_CAFEBABE_01234567, 4'd3);
    msg_valid_a = 1'b0;
    msg_data_a  = '1;
    drain_a();

    // Downstream ready toggling every cycle.
    f0 = fires_a;
    put_flit_ready_a = 1'b0;
    offer_a(100'h3_11112222_33334444_55556666, 4'd9);
    msg_valid_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (q_a.size() == 0) break;
      put_flit_ready_a = ~put_flit_ready_a;
      @(posedge CLK); #1;
    end
    put_flit_ready_a = 1'b1;
    check("stall_drain", q_a.size(), 0);
    check("stall_fire_count", fires_a - f0, 4);

    // Back-to-back packets, no bubble.
    f0 = fires_a;
    v0 = valid_cnt_a;
    offer_a(100'hA_AAAAAAAA_BBBBBBBB_CCCCCCCC, 4'd1);
    n0 = neg_cnt_a;
    offer_a(100'h5_DDDDDDDD_EEEEEEEE_12345678, 4'd2);
    msg_valid_a = 1'b0;
    drain_a();
    check("b2b_fires", fires_a - f0, 8);
    check("b2b_no_gap", last_fire_a - n0, 8);
    check("b2b_valid_cycles", valid_cnt_a - v0, 8);

    // Padding stays zero after an all-ones message.
    offer_a('1, 4'd15);
    offer_a(100'h5, 4'd4);
    msg_valid_a = 1'b0;
    drain_a();

    // Reset after two flits of a packet.
    f0 = fires_a;
    offer_a(100'h7_01010101_02020202_03030303, 4'd6);
    msg_valid_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (fires_a >= f0 + 2) break;
      @(posedge CLK); #1;
    end
    check("pre_reset_fires", fires_a - f0, 2);
    RST = 1'b1;
    q_a.delete();
    @(negedge CLK);
    check("midrst_valid", put_flit_valid_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_flit", put_flit_a, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("postrst_valid", put_flit_valid_a, 0);
    check("postrst_busy", busy_a, 0);
    check("postrst_msg_ready", msg_ready_a, 1);
    @(posedge CLK); #1;
    offer_a(100'h1_0000000A_0000000B_0000000C, 4'd8);
    msg_valid_a = 1'b0;
    drain_a();

    // Single-flit packets at one message per cycle.
    vals_b = '{32'h00000011, 32'hFFFFFFFF, 32'h80000001, 32'h12345678, 32'h0};
    f0 = fires_b;
    for (int i = 0; i < 5; i++) begin
      msg_data_b  = vals_b[i];
      msg_dest_b  = 4'(i + 2);
      msg_valid_b = 1'b1;
      @(negedge CLK);
      check("b_msg_ready", msg_ready_b, 1);
      if (i > 0) check("b_valid_continuous", put_flit_valid_b, 1);
      q_b.push_back({1'b1, 1'b1, 4'(i + 2), 2'd1, vals_b[i]});
      @(posedge CLK); #1;
    end
    msg_valid_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (q_b.size() == 0) break;
      @(posedge CLK); #1;
    end
    check("b_drain", q_b.size(), 0);
    check("b_fire_count", fires_b - f0, 5);

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
